// File: rtl/lynxTypes.sv
// Shared types for the TCP receive reader.
// Declares the bit-field layouts of the notify, read-package, rx-meta,
// header and notification-queue words, the reader FSM state enum, and
// small arithmetic helpers (tkeep popcount, saturating increment).
package lynxTypes;

    localparam int SID_W    = 16;
    localparam int LEN_W    = 16;
    localparam int NOTIFY_W = 88;
    localparam int RDPKG_W  = 40;
    localparam int RXMETA_W = 40;
    localparam int HDR_W    = 32;
    localparam int NQ_W     = 32;

    typedef struct packed {
        logic [6:0]       rsvd;
        logic             closed;
        logic [15:0]      port;
        logic [31:0]      ip;
        logic [LEN_W-1:0] len;
        logic [SID_W-1:0] sid;
    } notify_t;

    typedef struct packed {
        logic [7:0]       zero;
        logic [LEN_W-1:0] len;
        logic [SID_W-1:0] sid;
    } rd_pkg_t;

    typedef struct packed {
        logic [23:0]      ignored;
        logic [SID_W-1:0] sid;
    } rx_meta_t;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [SID_W-1:0] sid;
    } rx_hdr_t;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [SID_W-1:0] sid;
    } nq_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_META = 3'd2,
        ST_HDR  = 3'd3,
        ST_DATA = 3'd4
    } rx_state_t;

    // Number of valid bytes in a 64-byte beat.
    function automatic logic [6:0] popcount64(input logic [63:0] keep);
        logic [6:0] cnt;
        cnt = 7'd0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + {6'd0, keep[i]};
        end
        return cnt;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/tcp_notify_queue.sv
// Synchronous FIFO holding pending (sid, len) notifications.
// Ports: clk/reset (sync, active-high); push/din write side; pop/dout read
// side (dout is the head entry, valid while !empty); full/empty flags.
// A pop on a full queue frees the slot for a push in the same cycle; a push
// into an empty queue only becomes visible on the following cycle.
module tcp_notify_queue #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = mem_r[rd_ptr_r];

    // Storage write; contents need no reset because count_r guards reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking; power-of-two depth makes pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/tcp_rx_reader.sv
// TCP receive reader: turns session notifications into read-package
// requests of at most MAX_RD_LEN bytes, checks the returned rx_meta sid,
// emits one header per chunk and forwards the chunk payload unchanged.
// Ports: aclk/areset (sync, active-high); s_tcp_notify (closed -> m_close,
// otherwise queued); m_tcp_rd_pkg (read request); s_tcp_rx_meta (sid echo);
// s_axis_tcp_rx -> m_axis_rx payload pass-through while in DATA;
// m_rx_hdr (chunk header); err_len_cnt / err_sid_cnt saturating error counts.
module tcp_rx_reader
    import lynxTypes::*;
#(
    parameter int MAX_RD_LEN = 1024,
    parameter int NQ_DEPTH   = 8
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         s_tcp_notify_valid,
    output logic         s_tcp_notify_ready,
    input  logic [87:0]  s_tcp_notify_data,
    output logic         m_tcp_rd_pkg_valid,
    input  logic         m_tcp_rd_pkg_ready,
    output logic [39:0]  m_tcp_rd_pkg_data,
    input  logic         s_tcp_rx_meta_valid,
    output logic         s_tcp_rx_meta_ready,
    input  logic [39:0]  s_tcp_rx_meta_data,
    input  logic         s_axis_tcp_rx_tvalid,
    output logic         s_axis_tcp_rx_tready,
    input  logic [511:0] s_axis_tcp_rx_tdata,
    input  logic [63:0]  s_axis_tcp_rx_tkeep,
    input  logic         s_axis_tcp_rx_tlast,
    output logic         m_rx_hdr_valid,
    input  logic         m_rx_hdr_ready,
    output logic [31:0]  m_rx_hdr_data,
    output logic         m_axis_rx_tvalid,
    input  logic         m_axis_rx_tready,
    output logic [511:0] m_axis_rx_tdata,
    output logic [63:0]  m_axis_rx_tkeep,
    output logic         m_axis_rx_tlast,
    output logic         m_close_valid,
    input  logic         m_close_ready,
    output logic [15:0]  m_close_data,
    output logic [31:0]  err_len_cnt,
    output logic [31:0]  err_sid_cnt
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_RD_LEN);

    rx_state_t  state_r, state_nxt_s;
    logic [15:0] sid_r, rem_r, chunk_r;
    logic [16:0] byte_cnt_r;
    logic [31:0] err_len_r, err_sid_r;

    notify_t    ntf_s;
    rx_meta_t   meta_s;
    nq_entry_t  nq_head_s;
    logic [31:0] nq_dout_s;
    logic        nq_full_s, nq_empty_s, nq_push_s, pop_s;
    logic [15:0] chunk_s;
    logic [6:0]  beat_bytes_s;
    logic [16:0] byte_sum_s;
    logic        in_data_s, beat_s;
    logic        unused_s;

    assign ntf_s     = notify_t'(s_tcp_notify_data);
    assign meta_s    = rx_meta_t'(s_tcp_rx_meta_data);
    assign nq_head_s = nq_entry_t'(nq_dout_s);
    assign unused_s  = ^{ntf_s.rsvd, ntf_s.port, ntf_s.ip, meta_s.ignored};

    assign pop_s   = (state_r == ST_IDLE) && !nq_empty_s && !areset;
    assign chunk_s = (rem_r < MAX_LEN) ? rem_r : MAX_LEN;

    // Notify steering: closed sessions go straight to m_close, the rest
    // compete for a queue slot (a same-cycle pop frees one when full).
    always_comb begin
        s_tcp_notify_ready = 1'b0;
        m_close_valid      = 1'b0;
        if (areset) begin
            s_tcp_notify_ready = 1'b0;
            m_close_valid      = 1'b0;
        end else if (ntf_s.closed) begin
            s_tcp_notify_ready = m_close_ready;
            m_close_valid      = s_tcp_notify_valid;
        end else begin
            s_tcp_notify_ready = !nq_full_s || pop_s;
            m_close_valid      = 1'b0;
        end
    end

    assign m_close_data = ntf_s.sid;
    // Zero-length open notifications are accepted but never queued.
    assign nq_push_s = s_tcp_notify_valid && s_tcp_notify_ready &&
                       !ntf_s.closed && (ntf_s.len != 16'd0);

    tcp_notify_queue #(
        .DEPTH (NQ_DEPTH),
        .W     (NQ_W)
    ) u_queue (
        .clk   (aclk),
        .reset (areset),
        .push  (nq_push_s),
        .din   ({ntf_s.len, ntf_s.sid}),
        .pop   (pop_s),
        .dout  (nq_dout_s),
        .full  (nq_full_s),
        .empty (nq_empty_s)
    );

    // Handshake-facing outputs are pure functions of state so valid and data stay stable until accepted.
    assign m_tcp_rd_pkg_valid  = (state_r == ST_REQ)  && !areset;
    assign m_tcp_rd_pkg_data   = {8'd0, chunk_s, sid_r};
    assign s_tcp_rx_meta_ready = (state_r == ST_META) && !areset;
    assign m_rx_hdr_valid      = (state_r == ST_HDR)  && !areset;
    assign m_rx_hdr_data       = {chunk_r, sid_r};

    // Payload path: zero-latency pass-through gated to the DATA state.
    assign in_data_s            = (state_r == ST_DATA) && !areset;
    assign m_axis_rx_tvalid     = in_data_s && s_axis_tcp_rx_tvalid;
    assign s_axis_tcp_rx_tready = in_data_s && m_axis_rx_tready;
    assign m_axis_rx_tdata      = s_axis_tcp_rx_tdata;
    assign m_axis_rx_tkeep      = s_axis_tcp_rx_tkeep;
    assign m_axis_rx_tlast      = s_axis_tcp_rx_tlast;
    assign beat_s               = s_axis_tcp_rx_tvalid && s_axis_tcp_rx_tready;
    assign beat_bytes_s         = popcount64(s_axis_tcp_rx_tkeep);
    assign byte_sum_s           = byte_cnt_r + {10'd0, beat_bytes_s};

    assign err_len_cnt = err_len_r;
    assign err_sid_cnt = err_sid_r;

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) state_nxt_s = ST_REQ;
                else       state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (m_tcp_rd_pkg_ready) state_nxt_s = ST_META;
                else                    state_nxt_s = ST_REQ;
            end
            ST_META: begin
                if (s_tcp_rx_meta_valid) state_nxt_s = ST_HDR;
                else                     state_nxt_s = ST_META;
            end
            ST_HDR: begin
                if (m_rx_hdr_ready) state_nxt_s = ST_DATA;
                else                state_nxt_s = ST_HDR;
            end
            ST_DATA: begin
                if (beat_s && s_axis_tcp_rx_tlast) begin
                    state_nxt_s = (rem_r != 16'd0) ? ST_REQ : ST_IDLE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Session bookkeeping and error counters, updated on each state's handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            sid_r      <= 16'd0;
            rem_r      <= 16'd0;
            chunk_r    <= 16'd0;
            byte_cnt_r <= 17'd0;
            err_len_r  <= 32'd0;
            err_sid_r  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        sid_r <= nq_head_s.sid;
                        rem_r <= nq_head_s.len;
                    end
                end
                ST_REQ: begin
                    if (m_tcp_rd_pkg_ready) begin
                        chunk_r <= chunk_s;
                        rem_r   <= rem_r - chunk_s;
                    end
                end
                ST_META: begin
                    if (s_tcp_rx_meta_valid && (meta_s.sid != sid_r)) begin
                        err_sid_r <= sat_inc32(err_sid_r);
                    end
                end
                ST_HDR: begin
                    if (m_rx_hdr_ready) begin
                        byte_cnt_r <= 17'd0;
                    end
                end
                ST_DATA: begin
                    if (beat_s) begin
                        byte_cnt_r <= byte_sum_s;
                        if (s_axis_tcp_rx_tlast && (byte_sum_s != {1'b0, chunk_r})) begin
                            err_len_r <= sat_inc32(err_len_r);
                        end
                    end
                end
                default: begin
                    byte_cnt_r <= byte_cnt_r;
                end
            endcase
        end
    end

endmodule
